// File: rtl/key_entry_pkg.sv
// Shared constants and FSM state type for the keypad digit-entry sequencer.
package key_entry_pkg;

    localparam int unsigned NUM_KEYS            = 10;
    localparam int unsigned DIGIT_W             = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
    localparam int unsigned NUM_SLOTS_DEF       = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HOLD     = 2'd2,
        ST_REL_DB   = 2'd3
    } key_state_e;

endpackage

// File: rtl/key_onehot_dec.sv
// Combinational decode of the captured key snapshot into a digit index
// plus a flag that exactly one key was held.
module key_onehot_dec
    import key_entry_pkg::*;
(
    input  logic [NUM_KEYS-1:0] snap_i,
    output logic [DIGIT_W-1:0]  index_c_o,
    output logic                onehot_c_o
);

    always_comb begin
        index_c_o = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (snap_i[i]) begin
                index_c_o = DIGIT_W'(i);
            end
        end
        // A non-zero vector with no second bit set: clearing the lowest set bit leaves zero.
        onehot_c_o = (snap_i != '0) &&
                     ((snap_i & (snap_i - NUM_KEYS'(1))) == '0);
    end

endmodule

// File: rtl/key_entry_sequencer.sv
// Debounces a 10-key keypad, emits accepted digits and sequences them into
// NUM_SLOTS one-hot slot loads. Define KEY_SYNC_EN to add a two-flop input synchroniser.
module key_entry_sequencer
    import key_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned NUM_SLOTS       = NUM_SLOTS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_KEYS-1:0]  key_in,
    input  logic                 clear_in,
    output logic [DIGIT_W-1:0]   digit_out,
    output logic                 digit_valid,
    output logic [NUM_SLOTS-1:0] slot_load,
    output logic                 entry_full,
    output logic                 err_multi,
    output logic                 overflow
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PTR_W = $clog2(NUM_SLOTS + 1);

    logic [NUM_KEYS-1:0] k;
    logic                any_c;

`ifdef KEY_SYNC_EN
    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    assign k = sync2_q;
`else
    assign k = key_in;
`endif

    assign any_c = |k;

    key_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] snap_q, snap_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                full_q, full_d;

    logic [DIGIT_W-1:0]   digit_out_q, digit_out_d;
    logic                 digit_valid_q, digit_valid_d;
    logic [NUM_SLOTS-1:0] slot_load_q, slot_load_d;
    logic                 err_multi_q, err_multi_d;
    logic                 overflow_q, overflow_d;

    logic [DIGIT_W-1:0] dec_index_c;
    logic               dec_onehot_c;
    logic               accept_c;

    key_onehot_dec u_dec (
        .snap_i     (snap_q),
        .index_c_o  (dec_index_c),
        .onehot_c_o (dec_onehot_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and debounce counter / snapshot
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        case (state_q)
            ST_IDLE: begin
                if (any_c) begin
                    snap_d  = k;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_PRESS_DB;
                end
            end
            ST_PRESS_DB: begin
                if (k != snap_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!any_c) begin
                    cnt_d   = CNT_W'(1);
                    state_d = ST_REL_DB;
                end
            end
            ST_REL_DB: begin
                if (any_c) begin
                    state_d = ST_HOLD;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / slot-pointer decisions, registered below
    always_comb begin
        accept_c = (state_q == ST_PRESS_DB) && (k == snap_q) &&
                   (cnt_q == CNT_W'(DEBOUNCE_CYCLES));

        digit_out_d   = digit_out_q;
        digit_valid_d = 1'b0;
        slot_load_d   = '0;
        err_multi_d   = 1'b0;
        overflow_d    = 1'b0;
        ptr_d         = ptr_q;
        full_d        = full_q;

        if (clear_in) begin
            ptr_d  = '0;
            full_d = 1'b0;
        end

        if (accept_c) begin
            if (dec_onehot_c) begin
                digit_out_d   = dec_index_c;
                digit_valid_d = 1'b1;
                // A coincident clear wins over the slot write.
                if (!clear_in) begin
                    if (full_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        slot_load_d = NUM_SLOTS'(1) << ptr_q;
                        ptr_d       = ptr_q + PTR_W'(1);
                        if (ptr_q == PTR_W'(NUM_SLOTS - 1)) begin
                            full_d = 1'b1;
                        end
                    end
                end
            end else begin
                err_multi_d = 1'b1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            snap_q        <= '0;
            ptr_q         <= '0;
            full_q        <= 1'b0;
            digit_out_q   <= '0;
            digit_valid_q <= 1'b0;
            slot_load_q   <= '0;
            err_multi_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            snap_q        <= snap_d;
            ptr_q         <= ptr_d;
            full_q        <= full_d;
            digit_out_q   <= digit_out_d;
            digit_valid_q <= digit_valid_d;
            slot_load_q   <= slot_load_d;
            err_multi_q   <= err_multi_d;
            overflow_q    <= overflow_d;
        end
    end

    assign digit_out   = digit_out_q;
    assign digit_valid = digit_valid_q;
    assign slot_load   = slot_load_q;
    assign entry_full  = full_q;
    assign err_multi   = err_multi_q;
    assign overflow    = overflow_q;

endmodule
